// File: rtl/multicycle_seq_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer.
//   state_e          : sequencer state codes (also exported on the debug port)
//   TIMEOUT_DEFAULT  : default maximum ack wait, in request cycles
//   WAIT_W           : width of the memory-request wait counter
package multicycle_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERR    = 3'd7
    } state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned WAIT_W          = 16;

endpackage

// File: rtl/multicycle_seq_req_timer.sv
// Wait counter shared by the instruction-fetch and data-memory handshakes.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : hold the count at zero (asserted whenever no request is pending)
//   cnt_en   : a request is outstanding and has not been acked this cycle
//   expired  : this un-acked cycle is the TIMEOUT-th wait cycle
module multicycle_seq_req_timer
    import multicycle_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic cnt_en,
    output logic expired
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count holds the number of earlier wait cycles, so the current
    // cycle is the TIMEOUT-th one when the count equals TIMEOUT-1.
    assign expired = cnt_en && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle sequencer: steps each instruction through fetch, decode,
// execute, optional data-memory access and writeback.
//   clk, rst            : clock, asynchronous active-high reset
//   run                 : allows the next fetch to start
//   imem_req / imem_ack : instruction fetch handshake
//   ir_we               : instruction register load strobe (cycle of imem ack)
//   is_load, is_store,
//   wb_en, illegal      : decoded instruction attributes, sampled in DECODE
//   dmem_req / dmem_ack : data memory handshake, dmem_we = store qualifier
//   pc_we, rf_we        : one-cycle writeback strobes
//   err                 : sticky error, cleared only by rst
//   state               : current state code
//   instret             : retired instruction count, wrapping
module multicycle_seq
    import multicycle_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_we,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             wb_en,
    input  logic             illegal,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             pc_we,
    output logic             rf_we,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    state_e           state_q, state_d;
    logic             ld_q, ld_d, st_q, st_d, wb_q, wb_d;
    logic             imem_req_q, imem_req_d, dmem_req_q, dmem_req_d;
    logic             dmem_we_q, dmem_we_d, pc_we_q, pc_we_d;
    logic             rf_we_q, rf_we_d, err_q, err_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             wait_active, ack_now, tmr_expired;

    // The request flops are high exactly in FETCH / MEM, so an ack seen
    // while the matching request is low never counts.
    assign wait_active = imem_req_q || dmem_req_q;
    assign ack_now     = (imem_req_q && imem_ack) || (dmem_req_q && dmem_ack);

    multicycle_seq_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!wait_active),
        .cnt_en  (wait_active && !ack_now),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        ld_d      = ld_q;
        st_d      = st_q;
        wb_d      = wb_q;
        instret_d = instret_q;
        case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                // Ack takes priority over an expiring wait.
                if (imem_ack)         state_d = ST_DECODE;
                else if (tmr_expired) state_d = ST_ERR;
            end
            ST_DECODE: begin
                ld_d = is_load;
                st_d = is_store;
                wb_d = wb_en;
                if (illegal || (is_load && is_store)) state_d = ST_ERR;
                else                                  state_d = ST_EXEC;
            end
            ST_EXEC:   state_d = (ld_q || st_q) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_ack)         state_d = ST_WB;
                else if (tmr_expired) state_d = ST_ERR;
            end
            ST_WB: begin
                instret_d = instret_q + CNT_W'(1);
                state_d   = run ? ST_FETCH : ST_IDLE;
            end
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_ERR;
        endcase

        // Outputs are registered from the next state so they are clean
        // decodes of the current state once the edge has passed.
        imem_req_d = (state_d == ST_FETCH);
        dmem_req_d = (state_d == ST_MEM);
        dmem_we_d  = (state_d == ST_MEM) && st_d;
        pc_we_d    = (state_d == ST_WB);
        rf_we_d    = (state_d == ST_WB) && wb_d;
        err_d      = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
            wb_q       <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            pc_we_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            err_q      <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            ld_q       <= ld_d;
            st_q       <= st_d;
            wb_q       <= wb_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            pc_we_q    <= pc_we_d;
            rf_we_q    <= rf_we_d;
            err_q      <= err_d;
            instret_q  <= instret_d;
        end
    end

    // The instruction register loads in the same cycle the fetch is acked.
    assign ir_we    = imem_req_q && imem_ack;
    assign imem_req = imem_req_q;
    assign dmem_req = dmem_req_q;
    assign dmem_we  = dmem_we_q;
    assign pc_we    = pc_we_q;
    assign rf_we    = rf_we_q;
    assign err      = err_q;
    assign state    = state_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq. Each instruction is described by its fetch wait,
// kind, writeback flag and memory wait; the expected per-cycle outputs follow
// from that description, and instret is tracked as a count modulo 2^CNT_W.
module tb_multicycle_seq;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, run, imem_ack, is_load, is_store, wb_en, illegal, dmem_ack;
    logic          imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, err;
    logic [2:0]    state;
    logic [CW-1:0] instret;

    int vectors     = 0;
    int miscompares = 0;
    int exp_instret = 0;

    multicycle_seq #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .imem_req (imem_req),
        .imem_ack (imem_ack),
        .ir_we    (ir_we),
        .is_load  (is_load),
        .is_store (is_store),
        .wb_en    (wb_en),
        .illegal  (illegal),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .dmem_ack (dmem_ack),
        .pc_we    (pc_we),
        .rf_we    (rf_we),
        .err      (err),
        .state    (state),
        .instret  (instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int st, input bit ireq, input bit irw,
                           input bit dreq, input bit dwe, input bit pcw, input bit rfw,
                           input bit er);
        chk({tag, ".state"},    32'(state),    32'(st));
        chk({tag, ".imem_req"}, 32'(imem_req), 32'(ireq));
        chk({tag, ".ir_we"},    32'(ir_we),    32'(irw));
        chk({tag, ".dmem_req"}, 32'(dmem_req), 32'(dreq));
        chk({tag, ".dmem_we"},  32'(dmem_we),  32'(dwe));
        chk({tag, ".pc_we"},    32'(pc_we),    32'(pcw));
        chk({tag, ".rf_we"},    32'(rf_we),    32'(rfw));
        chk({tag, ".err"},      32'(err),      32'(er));
    endtask

    task automatic scramble();
        is_load  = 1'($urandom_range(0, 1));
        is_store = 1'($urandom_range(0, 1));
        wb_en    = 1'($urandom_range(0, 1));
        illegal  = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        is_load = 1'b0; is_store = 1'b0; wb_en = 1'b0; illegal = 1'b0;
        #1;
        chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.instret", 32'(instret), 0);
        tick();
        tick();
        rst = 1'b0;
        exp_instret = 0;
    endtask

    // From IDLE, raise run and move into the first FETCH cycle.
    task automatic start();
        run = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        chk_out("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    // Runs one instruction starting in its first FETCH cycle. A wait of TO or
    // more means the ack never arrives and the access must time out.
    task automatic do_instr(input int wf, input bit ld, input bit st, input bit wb,
                            input bit ill, input int wm, input bit run_after,
                            output bit died);
        int n;
        died = 1'b0;
        n = (wf < TO) ? wf + 1 : TO;
        for (int i = 0; i < n; i++) begin
            imem_ack = (i == wf);
            dmem_ack = 1'($urandom_range(0, 1));
            scramble();
            #1;
            chk_out("fetch", 1, 1, (i == wf), 0, 0, 0, 0, 0);
            tick();
        end
        imem_ack = 1'b0;
        if (wf >= TO) begin died = 1'b1; return; end

        imem_ack = 1'($urandom_range(0, 1));
        dmem_ack = 1'($urandom_range(0, 1));
        is_load = ld; is_store = st; wb_en = wb; illegal = ill;
        run = 1'($urandom_range(0, 1));
        #1;
        chk_out("decode", 2, 0, 0, 0, 0, 0, 0, 0);
        tick();
        scramble();
        if (ill || (ld && st)) begin died = 1'b1; return; end

        run = 1'($urandom_range(0, 1));
        #1;
        chk_out("exec", 3, 0, 0, 0, 0, 0, 0, 0);
        tick();

        if (ld || st) begin
            n = (wm < TO) ? wm + 1 : TO;
            for (int j = 0; j < n; j++) begin
                dmem_ack = (j == wm);
                imem_ack = 1'($urandom_range(0, 1));
                #1;
                chk_out("mem", 4, 0, 0, 1, st, 0, 0, 0);
                tick();
            end
            dmem_ack = 1'b0;
            if (wm >= TO) begin died = 1'b1; return; end
        end

        run = run_after;
        imem_ack = 1'($urandom_range(0, 1));
        dmem_ack = 1'($urandom_range(0, 1));
        #1;
        chk_out("wb", 5, 0, 0, 0, 0, 1, wb, 0);
        chk("wb.instret", 32'(instret), 32'(exp_instret));
        tick();
        exp_instret = (exp_instret + 1) % (1 << CW);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        chk("next.state", 32'(state), run_after ? 1 : 0);
        chk("next.imem_req", 32'(imem_req), 32'(run_after));
        chk("next.instret", 32'(instret), 32'(exp_instret));
    endtask

    // Stay in ERR regardless of run and acks.
    task automatic chk_err(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            run      = 1'($urandom_range(0, 1));
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            scramble();
            #1;
            chk_out("err", 7, 0, 0, 0, 0, 0, 0, 1);
            chk("err.instret", 32'(instret), 32'(exp_instret));
            tick();
        end
    endtask

    initial begin
        bit died, wb, ld, st, ra;
        int wf, wm, ty, idle_n;

        do_reset();

        // Directed: basic ALU, delayed load, store without writeback,
        // fetch ack on the last allowed cycle.
        start();
        do_instr(0, 0, 0, 1, 0, 0, 1, died);
        do_instr(0, 1, 0, 1, 0, 3, 1, died);
        do_instr(0, 0, 1, 0, 0, 1, 1, died);
        do_instr(TO - 1, 0, 0, 1, 0, 0, 1, died);
        do_instr(1, 0, 1, 1, 0, TO - 1, 0, died);
        start();

        // Random instruction mix, no timeouts.
        for (int k = 0; k < 40; k++) begin
            wf = $urandom_range(0, TO - 1);
            wm = $urandom_range(0, TO - 1);
            ty = $urandom_range(0, 2);
            ld = (ty == 1);
            st = (ty == 2);
            wb = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 4) != 0);
            do_instr(wf, ld, st, wb, 0, wm, ra, died);
            if (!ra) begin
                idle_n = $urandom_range(0, 3);
                for (int i = 0; i < idle_n; i++) begin
                    run = 1'b0;
                    imem_ack = 1'($urandom_range(0, 1));
                    #1;
                    chk_out("idle.hold", 0, 0, 0, 0, 0, 0, 0, 0);
                    tick();
                end
                start();
            end
        end

        // Reset in the middle of a data access.
        imem_ack = 1'b1;
        #1;
        chk("rstmem.ir_we", 32'(ir_we), 1);
        tick();
        imem_ack = 1'b0; is_load = 1'b1; is_store = 1'b0; wb_en = 1'b1; illegal = 1'b0;
        tick();
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("rstmem.dmem_req", 32'(dmem_req), 1);
        rst = 1'b1;
        #1;
        chk_out("rstmem", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rstmem.instret", 32'(instret), 0);
        do_reset();

        // Counter wrap: 2^CW retirements from reset bring instret back to 0.
        start();
        for (int k = 0; k < (1 << CW); k++) do_instr(0, 0, 0, 1, 0, 0, 1, died);
        chk("wrap.instret", 32'(instret), 0);

        // Fetch timeout, then ERR is sticky.
        do_reset();
        start();
        do_instr(TO, 0, 0, 1, 0, 0, 1, died);
        chk_err(10);

        // Illegal opcode.
        do_reset();
        start();
        do_instr(0, 0, 0, 1, 1, 0, 1, died);
        chk_err(3);

        // Load and store together.
        do_reset();
        start();
        do_instr(0, 1, 1, 1, 0, 0, 1, died);
        chk_err(3);

        // Data memory timeout after one good instruction.
        do_reset();
        start();
        do_instr(0, 0, 0, 1, 0, 0, 1, died);
        do_instr(0, 0, 1, 1, 0, TO, 1, died);
        chk_err(3);

        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_seq.md
# multicycle_seq

Multi-cycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, optional data-memory access and writeback, and drives handshaked requests to instruction and data memory. It emits one-cycle write strobes for the instruction register, PC and register file. It sits between the decoder and the memory ports, and keeps a retired-instruction counter and a sticky error flag.

## Interface
- TIMEOUT, 255: maximum cycles a memory request may wait for ack before error; legal range 1..65535.
- CNT_W, 32: width of retired-instruction counter.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- run  in  1  level; 1 lets the sequencer start or continue fetching.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction memory done; instruction valid this cycle.
- ir_we  out  1  one-cycle strobe to latch the instruction register.
- is_load  in  1  decoded load, from the instruction register.
- is_store  in  1  decoded store, from the instruction register.
- wb_en  in  1  decoded register writeback enable, active-high.
- illegal  in  1  decoded opcode not supported.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write qualifier, valid only while dmem_req=1.
- dmem_ack  in  1  data memory done.
- pc_we  out  1  one-cycle PC update strobe.
- rf_we  out  1  one-cycle register-file write strobe.
- err  out  1  sticky error; cleared only by rst.
- state  out  3  current state code, for debug.
- instret  out  CNT_W  retired instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERR.
- IDLE: go to FETCH when run=1; otherwise stay.
- FETCH: imem_req=1. When imem_ack=1, pulse ir_we in the same cycle and go to DECODE.
- DECODE: register is_load, is_store and wb_en into internal flags.
  - illegal=1 goes to ERR.
  - is_load=1 together with is_store=1 goes to ERR.
  - Otherwise go to EXEC.
- EXEC: one cycle. Go to MEM if the load or store flag is set; else go to WB.
- MEM: dmem_req=1 and dmem_we=store flag. When dmem_ack=1, go to WB.
- WB: pc_we=1, rf_we=registered wb_en flag, instret+=1. Then go to FETCH if run=1, else to IDLE.
- ERR: all strobes and requests are 0 and err=1. The sequencer stays in ERR until rst.
- Handshake rules:
  - A request rises on entry to FETCH or MEM and stays high and stable until ack is sampled high.
  - The request drops in the cycle after ack.
  - ack while the matching request is low is ignored.
- Timeout:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle the request is high without ack.
  - If the counter reaches TIMEOUT with no ack, go to ERR next edge instead.
  - If ack arrives in the same cycle the counter reaches TIMEOUT, ack wins and the access completes.
- run=0 during an instruction does not abort it. It only blocks the next FETCH.
- instret wraps to 0 after all-ones. No saturation.

## Timing
- Reset values:
  - state=IDLE (code 0).
  - All outputs 0: imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, err, instret.
  - Wait counter 0.
- With zero-wait memory (ack in the first request cycle):
  - non-memory instruction takes 4 cycles (FETCH, DECODE, EXEC, WB);
  - load or store takes 5 cycles.
- Each wait cycle adds one cycle to FETCH or MEM.
- ir_we, pc_we and rf_we are high for exactly one cycle per instruction.
- Reset asserted mid-access drops every request immediately (asynchronously), with no completion strobe.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=7. Code 6 is unreachable; if entered, go to ERR.

## Structure
- The shared core package holds:
  - the state enum and its codes;
  - the TIMEOUT default constant.
- Sub-module req_timer holds the 16-bit wait counter.
  - Inputs: clear, count-enable.
  - Output: expired flag.
  - One instance is shared by FETCH and MEM, since they are mutually exclusive.

## Test plan
- Reset, then run=1, imem_ack=1 on the first request cycle, with a non-memory instruction and wb_en=1 → ir_we at cycle 1 and pc_we/rf_we at cycle 4. instret steps 0→1 and the next imem_req rises at cycle 5.
- Load with dmem_ack delayed 3 cycles → dmem_req high for 4 cycles, dmem_we=0, the instruction completes in 8 cycles, and rf_we fires once.
- Store with wb_en=0 → dmem_we=1 throughout MEM and rf_we stays 0 in WB.
- Never assert imem_ack, with TIMEOUT=4 → err=1 after 4 request cycles, state=7, imem_req=0. Later ack and run toggles have no effect until rst.
- illegal=1 in DECODE, and separately is_load=is_store=1 → ERR entered on the next edge, with no pc_we or rf_we.
- rst asserted mid-MEM → all outputs 0 immediately and state=IDLE. Also preload instret to all-ones via 2^CNT_W retirements (with CNT_W=4) → wraps to 0.
